// File: rtl/spawn_pkg.sv
// Shared types and ring-pointer helpers for the entity spawn scheduler.
package spawn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSpawn,
    StSettle,
    StDrain,
    StHalt
  } state_t;

  // Type code 0 marks an empty/unassigned slot; real types are 1..TYPE_COUNT.
  localparam int unsigned TypeNone = 0;

  function automatic int unsigned incr_mod(input int unsigned v, input int unsigned depth);
    return (v + 1 >= depth) ? 0 : v + 1;
  endfunction

  function automatic int unsigned decr_mod(input int unsigned v, input int unsigned depth);
    return (v == 0) ? depth - 1 : v - 1;
  endfunction

endpackage

// File: rtl/spawn_type_picker.sv
// Combinational type search: first candidate that meets its speed floor and
// would not exceed the consecutive-duplicate limit.
module spawn_type_picker
  import spawn_pkg::*;
#(
  parameter int unsigned TYPE_COUNT = 4,
  parameter int unsigned MAX_DUP    = 2,
  parameter int unsigned SPEED_W    = 15,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TYPE_W     = 3,
  parameter int unsigned HIST       = 2
) (
  input  logic [10:0]                        rng_i,
  input  logic [SPEED_W-1:0]                 speed_i,
  input  logic [TYPE_COUNT:0][SPEED_W-1:0]   min_speed_i,
  input  logic [HIST-1:0][TYPE_W-1:0]        hist_i,
  input  logic [CNT_W-1:0]                   count_i,
  output logic                               valid_o,
  output logic [TYPE_W-1:0]                  type_o
);

  logic [TYPE_COUNT-1:0][TYPE_W-1:0] cand;
  logic [TYPE_COUNT-1:0]             cand_ok;

  for (genvar g = 0; g < TYPE_COUNT; g++) begin : g_cand
    logic dup_l;

    assign cand[g] = TYPE_W'((32'(rng_i) + 32'(g)) % TYPE_COUNT + 1);

    // Duplicate only when the newest MAX_DUP occupied slots all hold this type.
    always_comb begin
      dup_l = (MAX_DUP != 0) && (32'(count_i) >= MAX_DUP);
      for (int unsigned k = 0; k < HIST; k++) begin
        if (hist_i[k] != cand[g]) dup_l = 1'b0;
      end
    end

    assign cand_ok[g] = (speed_i >= min_speed_i[cand[g]]) && !dup_l;
  end

  // Walk downwards so the lowest-index acceptable candidate wins.
  always_comb begin
    valid_o = 1'b0;
    type_o  = TYPE_W'(TypeNone);
    for (int i = int'(TYPE_COUNT) - 1; i >= 0; i--) begin
      if (cand_ok[i]) begin
        valid_o = 1'b1;
        type_o  = cand[i];
      end
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Ring-queue spawn scheduler: per frame update it spawns at most one entity,
// strobes all slots, then drains off-screen slots from the front.
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int unsigned DEPTH      = 7,
  parameter int unsigned TYPE_COUNT = 4,
  parameter int unsigned MAX_DUP    = 2,
  parameter bit          RAND_GATE  = 1'b0,
  parameter int unsigned GAME_WIDTH = 640,
  parameter int unsigned SPEED_W    = 15,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned TYPE_W    = $clog2(TYPE_COUNT + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               update_i,
  input  logic                               start_i,
  input  logic                               crash_i,
  input  logic                               enable_i,
  input  logic [SPEED_W-1:0]                 speed_i,
  input  logic [10:0]                        rng_i,
  input  logic [TYPE_COUNT:0][SPEED_W-1:0]   min_speed_i,
  input  logic [DEPTH-1:0]                   slot_remove_i,
  input  logic [DEPTH-1:0]                   slot_visible_i,
  input  logic [DEPTH-1:0][10:0]             slot_x_pos_i,
  input  logic [DEPTH-1:0][9:0]              slot_width_i,
  input  logic [DEPTH-1:0][10:0]             slot_gap_i,
  output logic [DEPTH-1:0]                   slot_start_o,
  output logic [DEPTH-1:0][TYPE_W-1:0]       slot_type_o,
  output logic                               slot_update_o,
  output logic [PTR_W-1:0]                   front_o,
  output logic [PTR_W:0]                     count_o,
  output logic                               done_o
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HIST  = (MAX_DUP == 0) ? 1 : MAX_DUP;

  state_t                          state_q, state_d;
  logic [PTR_W-1:0]                front_q, front_d;
  logic [PTR_W-1:0]                back_q, back_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [DEPTH-1:0]                slot_start_q, slot_start_d;
  logic [DEPTH-1:0][TYPE_W-1:0]    slot_type_q, slot_type_d;
  logic                            slot_update_q, slot_update_d;
  logic                            done_q, done_d;

  logic [PTR_W-1:0]                last_idx;
  logic [HIST-1:0][TYPE_W-1:0]     hist;
  logic                            pick_valid;
  logic [TYPE_W-1:0]               pick_type;
  logic signed [12:0]              edge_sum;
  logic                            room_ok;
  logic                            gate_ok;
  logic                            spawn_ok;

  assign last_idx = PTR_W'(decr_mod(32'(back_q), DEPTH));

  // Newest-first type history, walking backwards from the last spawned slot.
  always_comb begin
    int unsigned p;
    p    = 32'(last_idx);
    hist = '0;
    for (int unsigned k = 0; k < HIST; k++) begin
      hist[k] = slot_type_q[p[PTR_W-1:0]];
      p       = decr_mod(p, DEPTH);
    end
  end

  spawn_type_picker #(
    .TYPE_COUNT (TYPE_COUNT),
    .MAX_DUP    (MAX_DUP),
    .SPEED_W    (SPEED_W),
    .CNT_W      (CNT_W),
    .TYPE_W     (TYPE_W),
    .HIST       (HIST)
  ) u_picker (
    .rng_i       (rng_i),
    .speed_i     (speed_i),
    .min_speed_i (min_speed_i),
    .hist_i      (hist),
    .count_i     (count_q),
    .valid_o     (pick_valid),
    .type_o      (pick_type)
  );

  // Right edge of the newest entity plus its requested gap, as signed 13-bit.
  assign edge_sum = $signed({{2{slot_x_pos_i[last_idx][10]}}, slot_x_pos_i[last_idx]})
                  + $signed({3'b000, slot_width_i[last_idx]})
                  + $signed({2'b00, slot_gap_i[last_idx]});
  assign room_ok  = edge_sum < $signed(13'(GAME_WIDTH));

  always_comb begin
    if (count_q == '0) begin
      gate_ok = enable_i;
    end else if (count_q == CNT_W'(DEPTH)) begin
      gate_ok = 1'b0;
    end else begin
      gate_ok = enable_i && slot_visible_i[last_idx] && (!RAND_GATE || rng_i[0]) && room_ok;
    end
    spawn_ok = gate_ok && pick_valid;
  end

  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    back_d        = back_q;
    count_d       = count_q;
    slot_start_d  = slot_start_q;
    slot_type_d   = slot_type_q;
    slot_update_d = slot_update_q;
    done_d        = 1'b0;

    if (state_q != StIdle && crash_i) begin
      state_d       = StHalt;
      slot_update_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) state_d = StRun;
        end
        StRun: begin
          if (update_i) state_d = StSpawn;
        end
        StSpawn: begin
          // Strobe lands together with the new slot's start.
          slot_update_d = 1'b1;
          if (spawn_ok) begin
            slot_start_d[back_q] = 1'b1;
            slot_type_d[back_q]  = pick_type;
            back_d               = PTR_W'(incr_mod(32'(back_q), DEPTH));
            count_d              = count_q + CNT_W'(1);
          end
          state_d = StSettle;
        end
        StSettle: begin
          slot_update_d = 1'b0;
          state_d       = StDrain;
        end
        StDrain: begin
          if (count_q != '0 && slot_remove_i[front_q]) begin
            slot_start_d[front_q] = 1'b0;
            front_d               = PTR_W'(incr_mod(32'(front_q), DEPTH));
            count_d               = count_q - CNT_W'(1);
          end else begin
            done_d  = 1'b1;
            state_d = StRun;
          end
        end
        StHalt: begin
          slot_update_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      front_q       <= '0;
      back_q        <= '0;
      count_q       <= '0;
      slot_start_q  <= '0;
      slot_type_q   <= '0;
      slot_update_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      back_q        <= back_d;
      count_q       <= count_d;
      slot_start_q  <= slot_start_d;
      slot_type_q   <= slot_type_d;
      slot_update_q <= slot_update_d;
      done_q        <= done_d;
    end
  end

  assign slot_start_o  = slot_start_q;
  assign slot_type_o   = slot_type_q;
  assign slot_update_o = slot_update_q;
  assign front_o       = front_q;
  assign count_o       = count_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with default parameters (DEPTH=7, 4 types).
module tb_spawn_scheduler;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              update = 1'b0;
  logic              start = 1'b0;
  logic              crash = 1'b0;
  logic              enable = 1'b0;
  logic [14:0]       speed = 15'd100;
  logic [10:0]       rng = 11'd0;
  logic [4:0][14:0]  min_speed = '0;
  logic [6:0]        slot_remove = '0;
  logic [6:0]        slot_visible = '0;
  logic [6:0][10:0]  slot_x_pos = '0;
  logic [6:0][9:0]   slot_width = '0;
  logic [6:0][10:0]  slot_gap = '0;
  logic [6:0]        slot_start;
  logic [6:0][2:0]   slot_type;
  logic              slot_update;
  logic [2:0]        front;
  logic [3:0]        count;
  logic              done;

  int tests = 0;
  int fails = 0;
  int exp_t[7] = '{1, 1, 2, 1, 1, 2, 1};

  spawn_scheduler u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .update_i       (update),
    .start_i        (start),
    .crash_i        (crash),
    .enable_i       (enable),
    .speed_i        (speed),
    .rng_i          (rng),
    .min_speed_i    (min_speed),
    .slot_remove_i  (slot_remove),
    .slot_visible_i (slot_visible),
    .slot_x_pos_i   (slot_x_pos),
    .slot_width_i   (slot_width),
    .slot_gap_i     (slot_gap),
    .slot_start_o   (slot_start),
    .slot_type_o    (slot_type),
    .slot_update_o  (slot_update),
    .front_o        (front),
    .count_o        (count),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_geom(input logic [10:0] x, input logic [9:0] w, input logic [10:0] g);
    for (int i = 0; i < 7; i++) begin
      slot_x_pos[i] = x;
      slot_width[i] = w;
      slot_gap[i]   = g;
    end
  endtask

  // Pulse update from RUN; n = cycles from the SPAWN cycle until done is seen.
  task automatic do_update(output int n);
    update = 1'b1;
    tick();
    update = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_front", 32'(front), 0);
    chk("rst_start", 32'(slot_start), 0);
    chk("rst_type", 32'(slot_type), 0);
    chk("rst_update", 32'(slot_update), 0);
    chk("rst_done", 32'(done), 0);

    // Update while IDLE is ignored.
    enable = 1'b1;
    update = 1'b1;
    tick();
    tick();
    update = 1'b0;
    chk("idle_upd_count", 32'(count), 0);
    chk("idle_upd_strobe", 32'(slot_update), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    chk("first_start", 32'(slot_start), 32'h01);
    chk("first_strobe", 32'(slot_update), 1);
    chk("first_count", 32'(count), 1);
    chk("first_type", 32'(slot_type[0]), 1);
    tick();
    chk("settle_strobe_clr", 32'(slot_update), 0);
    chk("settle_no_done", 32'(done), 0);
    tick();
    chk("first_done", 32'(done), 1);
    tick();
    chk("done_one_cycle", 32'(done), 0);

    // Fill the ring; rng=0 exercises the duplicate limit along the way.
    slot_visible = '1;
    set_geom(11'd0, 10'd0, 11'd0);
    repeat (6) begin
      do_update(n);
      chk("fill_latency", 32'(n), 3);
    end
    chk("fill_count", 32'(count), 7);
    chk("fill_front", 32'(front), 0);
    chk("fill_start", 32'(slot_start), 32'h7f);
    for (int i = 0; i < 7; i++) chk("fill_type", 32'(slot_type[i]), 32'(exp_t[i]));

    set_geom(11'd100, 10'd20, 11'd50);
    do_update(n);
    chk("full_latency", 32'(n), 3);
    chk("full_count", 32'(count), 7);
    chk("full_front", 32'(front), 0);
    chk("full_start", 32'(slot_start), 32'h7f);

    enable = 1'b0;
    slot_remove = 7'b0011111;
    do_update(n);
    slot_remove = '0;
    chk("pop5_latency", 32'(n), 8);
    chk("pop5_front", 32'(front), 5);
    chk("pop5_count", 32'(count), 2);
    chk("pop5_start", 32'(slot_start), 32'h60);

    // Build history [2,2], then rng=5 must skip type 2 and pick 3.
    enable = 1'b1;
    rng = 11'd1;
    do_update(n);
    do_update(n);
    rng = 11'd5;
    do_update(n);
    chk("dup_hist0", 32'(slot_type[0]), 2);
    chk("dup_hist1", 32'(slot_type[1]), 2);
    chk("dup_pick", 32'(slot_type[2]), 3);
    chk("dup_count", 32'(count), 5);

    enable = 1'b0;
    slot_remove = 7'b1100001;
    do_update(n);
    slot_remove = '0;
    chk("wrap_latency", 32'(n), 6);
    chk("wrap_front", 32'(front), 1);
    chk("wrap_count", 32'(count), 2);
    chk("wrap_start", 32'(slot_start), 32'h06);
    chk("wrap_type_kept", 32'(slot_type[5]), 2);

    enable = 1'b1;
    rng = 11'd0;
    set_geom(-11'sd30, 10'd20, 11'd600);
    do_update(n);
    chk("edge590_count", 32'(count), 3);
    chk("edge590_type", 32'(slot_type[3]), 1);
    set_geom(-11'sd30, 10'd20, 11'd650);
    do_update(n);
    chk("edge640_count", 32'(count), 3);
    set_geom(-11'sd30, 10'd20, 11'd600);
    slot_visible = '0;
    do_update(n);
    chk("invisible_count", 32'(count), 3);
    slot_visible = '1;
    for (int i = 1; i < 5; i++) min_speed[i] = 15'd200;
    do_update(n);
    chk("speed_floor_count", 32'(count), 3);
    min_speed = '0;

    // Crash during the first DRAIN cycle blocks the pending pop.
    enable = 1'b0;
    slot_remove = 7'b0000110;
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    tick();
    crash = 1'b1;
    tick();
    crash = 1'b0;
    chk("halt_front", 32'(front), 1);
    chk("halt_count", 32'(count), 3);
    chk("halt_start", 32'(slot_start), 32'h0e);
    chk("halt_strobe", 32'(slot_update), 0);
    start = 1'b1;
    update = 1'b1;
    enable = 1'b1;
    slot_remove = '1;
    repeat (4) tick();
    chk("halt_hold_front", 32'(front), 1);
    chk("halt_hold_count", 32'(count), 3);
    chk("halt_hold_start", 32'(slot_start), 32'h0e);
    chk("halt_hold_done", 32'(done), 0);
    start = 1'b0;
    update = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rerst_count", 32'(count), 0);
    chk("rerst_front", 32'(front), 0);
    chk("rerst_start", 32'(slot_start), 0);
    chk("rerst_type", 32'(slot_type), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
